// File: rtl/trng_uart_collector.sv
// TRNG consumer: decimates trnd_byte, folds to one bit, packs bytes, buffers them in a FIFO and ships them over 8N1 UART.
// Define TRNG_VN_EN to insert a von Neumann corrector between the fold and the byte assembler.
`timescale 1ns/1ps

module trng_uart_collector #(
    parameter int SAMPLE_DIV = 64,
    parameter int BAUD_DIV   = 434,
    parameter int FIFO_AW    = 4
) (
    input  logic               clk,
    input  logic               rst_n_buf,
    input  logic [7:0]         trnd_byte,
    input  logic               en,
    output logic [7:0]         rnd_data,
    output logic               rnd_valid,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               overflow,
    output logic               uart_tx,
    output logic               tx_busy
);

    localparam int SCNT_W = $clog2(SAMPLE_DIV);
    localparam int BAUD_W = $clog2(BAUD_DIV);
    localparam int DEPTH  = 2 ** FIFO_AW;
    localparam logic [SCNT_W-1:0]  SCNT_LAST = SCNT_W'(SAMPLE_DIV - 1);
    localparam logic [BAUD_W-1:0]  BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [FIFO_AW:0]   LVL_FULL  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   LVL_ONE   = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [SCNT_W-1:0] r_scnt;
    logic              w_tick;
    logic              w_bit;
    logic              w_acc_vld;
    logic              w_acc_bit;

    assign w_tick = en && (r_scnt == SCNT_LAST);
    assign w_bit  = ^trnd_byte;

    always_ff @(posedge clk or negedge rst_n_buf) begin
        if (!rst_n_buf)
            r_scnt <= '0;
        else if (!en || w_tick)
            r_scnt <= '0;
        else
            r_scnt <= r_scnt + SCNT_W'(1);
    end

`ifdef TRNG_VN_EN
    logic r_have_first;
    logic r_first;

    always_ff @(posedge clk or negedge rst_n_buf) begin
        if (!rst_n_buf) begin
            r_have_first <= 1'b0;
            r_first      <= 1'b0;
        end else if (w_tick) begin
            if (!r_have_first)
                r_first <= w_bit;
            r_have_first <= !r_have_first;
        end
    end

    assign w_acc_vld = w_tick && r_have_first && (w_bit != r_first);
    assign w_acc_bit = r_first;
`else
    assign w_acc_vld = w_tick;
    assign w_acc_bit = w_bit;
`endif

    // Only the upper seven shift-register bits survive the next shift, so sr[0] is never stored.
    logic [6:0] r_sr;
    logic [2:0] r_bcnt;
    logic [7:0] r_data;
    logic       r_valid;
    logic [7:0] w_sr_nxt;
    logic       w_push;

    assign w_sr_nxt = {w_acc_bit, r_sr};
    assign w_push   = w_acc_vld && (r_bcnt == 3'd7);

    always_ff @(posedge clk or negedge rst_n_buf) begin
        if (!rst_n_buf) begin
            r_sr    <= '0;
            r_bcnt  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_push;
            if (w_acc_vld) begin
                r_sr   <= w_sr_nxt[7:1];
                r_bcnt <= r_bcnt + 3'd1;
            end
            if (w_push)
                r_data <= w_sr_nxt;
        end
    end

    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_level;
    logic               r_ovf;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_wr;

    assign w_full  = (r_level == LVL_FULL);
    assign w_empty = (r_level == '0);
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign w_wr    = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wptr] <= w_sr_nxt;
    end

    always_ff @(posedge clk or negedge rst_n_buf) begin
        if (!rst_n_buf) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr)
                r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)
                r_rptr <= r_rptr + PTR_ONE;
            if (w_wr && !w_pop)
                r_level <= r_level + LVL_ONE;
            else if (!w_wr && w_pop)
                r_level <= r_level - LVL_ONE;
            if (w_push && !w_wr)
                r_ovf <= 1'b1;
        end
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BAUD_W-1:0]  r_baud;
    logic [BAUD_W-1:0]  w_baud_nxt;
    logic [2:0]         r_bit;
    logic [2:0]         w_bit_nxt;
    logic [7:0]         r_txsh;
    logic [7:0]         w_txsh_nxt;
    logic               r_tx;
    logic               w_tx_nxt;
    logic               w_baud_end;

    assign w_baud_end = (r_baud == BAUD_LAST);

    always_ff @(posedge clk or negedge rst_n_buf) begin
        if (!rst_n_buf) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_txsh  <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_txsh  <= w_txsh_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_txsh_nxt  = r_txsh;
        w_pop       = 1'b0;
        w_tx_nxt    = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_txsh_nxt  = r_mem[r_rptr];
                    w_baud_nxt  = '0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_DATA;
                end else begin
                    w_baud_nxt = r_baud + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    w_baud_nxt = '0;
                    w_txsh_nxt = {1'b0, r_txsh[7:1]};
                    if (r_bit == 3'd7)
                        w_state_nxt = S_STOP;
                    else
                        w_bit_nxt = r_bit + 3'd1;
                end else begin
                    w_baud_nxt = r_baud + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_baud_nxt = r_baud + BAUD_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Line level is registered from the next state so the pin never sees decode glitches.
        case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_txsh_nxt[0];
            default: w_tx_nxt = 1'b1;
        endcase
    end

    assign rnd_data   = r_data;
    assign rnd_valid  = r_valid;
    assign fifo_level = r_level;
    assign overflow   = r_ovf;
    assign uart_tx    = r_tx;
    assign tx_busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_trng_uart_collector.sv
// Self-checking bench for trng_uart_collector: cycle model + byte scoreboard, directed steps in one initial block.
`timescale 1ns/1ps

module tb_trng_uart_collector;

    localparam int SD    = 4;
    localparam int BD    = 20;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
`ifdef TRNG_VN_EN
    localparam int TPB = 2;
`else
    localparam int TPB = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n_buf = 1'b0;
    logic [7:0]    trnd_byte = 8'h00;
    logic          en = 1'b0;
    logic [7:0]    rnd_data;
    logic          rnd_valid;
    logic [AW:0]   fifo_level;
    logic          overflow;
    logic          uart_tx;
    logic          tx_busy;

    always #5 clk = ~clk;

    trng_uart_collector #(.SAMPLE_DIV(SD), .BAUD_DIV(BD), .FIFO_AW(AW)) dut (
        .clk(clk), .rst_n_buf(rst_n_buf), .trnd_byte(trnd_byte), .en(en),
        .rnd_data(rnd_data), .rnd_valid(rnd_valid), .fifo_level(fifo_level),
        .overflow(overflow), .uart_tx(uart_tx), .tx_busy(tx_busy)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: behaviour of the collector in plain integer form.
    logic [7:0] q_rnd[$];
    logic [7:0] q_tx[$];
    int         m_scnt, m_bcnt, m_level, m_frame;
    logic       m_hf, m_first, m_ovf, m_vld;
    logic [7:0] m_sr;
    logic       m_tick, m_b, m_acc, m_abit, m_push, m_pop, m_wr;
    logic [7:0] m_byte;

    always_comb begin
        m_tick = en && (m_scnt == SD - 1);
        m_b    = ^trnd_byte;
        if (TPB == 2) begin
            m_acc  = m_tick && m_hf && (m_b != m_first);
            m_abit = m_first;
        end else begin
            m_acc  = m_tick;
            m_abit = m_b;
        end
        m_byte = {m_abit, m_sr[7:1]};
        m_push = m_acc && (m_bcnt == 7);
        m_pop  = (m_frame == 0) && (m_level != 0);
        m_wr   = m_push && ((m_level < DEPTH) || m_pop);
    end

    always @(posedge clk or negedge rst_n_buf) begin
        if (!rst_n_buf) begin
            m_scnt <= 0; m_bcnt <= 0; m_level <= 0; m_frame <= 0;
            m_hf <= 1'b0; m_first <= 1'b0; m_ovf <= 1'b0; m_vld <= 1'b0; m_sr <= 8'h00;
            q_rnd.delete();
            q_tx.delete();
        end else begin
            m_scnt <= (!en || m_tick) ? 0 : m_scnt + 1;
            if (m_tick && TPB == 2) begin
                m_hf <= !m_hf;
                if (!m_hf) m_first <= m_b;
            end
            if (m_acc) begin
                m_sr   <= m_byte;
                m_bcnt <= (m_bcnt + 1) % 8;
            end
            m_vld <= m_push;
            if (m_push) q_rnd.push_back(m_byte);
            if (m_wr) q_tx.push_back(m_byte);
            if (m_push && !m_wr) m_ovf <= 1'b1;
            m_level <= m_level + (m_wr ? 1 : 0) - (m_pop ? 1 : 0);
            if (m_pop) m_frame <= 10 * BD;
            else if (m_frame > 0) m_frame <= m_frame - 1;
        end
    end

    int rst_events = 0;
    always @(negedge rst_n_buf) rst_events++;

    task automatic cyc_mon();
        forever begin
            @(negedge clk);
            if (rst_n_buf) begin
                chk("fifo_level", fifo_level, m_level);
                chk("overflow", overflow, m_ovf);
                chk("tx_busy", tx_busy, m_frame != 0);
                chk("rnd_valid", rnd_valid, m_vld);
                if (rnd_valid) begin
                    chk("rnd_queue_nonempty", q_rnd.size() > 0, 1);
                    if (q_rnd.size() > 0) chk("rnd_data_sb", rnd_data, q_rnd.pop_front());
                end
            end
        end
    endtask

    task automatic uart_mon();
        logic [9:0] f;
        int r0;
        forever begin
            @(negedge uart_tx);
            r0 = rst_events;
            repeat (BD / 2) @(posedge clk);
            #1 f[0] = uart_tx;
            for (int i = 1; i < 10; i++) begin
                repeat (BD) @(posedge clk);
                #1 f[i] = uart_tx;
            end
            if (r0 == rst_events && rst_n_buf) begin
                chk("uart_start_bit", f[0], 0);
                chk("uart_stop_bit", f[9], 1);
                chk("uart_queue_nonempty", q_tx.size() > 0, 1);
                if (q_tx.size() > 0) chk("uart_byte", f[8:1], q_tx.pop_front());
            end
        end
    endtask

    function automatic logic [7:0] par_byte(input logic p);
        logic [7:0] r;
        r = 8'($urandom);
        r[0] = r[0] ^ (^r) ^ p;
        return r;
    endfunction

    // Callers start on a negedge with the sample counter at zero.
    task automatic drive_bits(input logic [7:0] v, input int n);
        for (int k = 0; k < n; k++)
            for (int t = 0; t < TPB; t++) begin
                trnd_byte = par_byte(v[k] ^ t[0]);
                repeat (SD) @(negedge clk);
            end
    endtask

    task automatic drive_raw(input logic [7:0] a, input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            trnd_byte = (i % 2 == 0) ? a : b;
            repeat (SD) @(negedge clk);
        end
    endtask

    task automatic wait_valid(input int budget, output int cyc, output bit got);
        cyc = 0;
        got = 1'b0;
        while (cyc < budget && !got) begin
            @(posedge clk);
            #1;
            cyc++;
            if (rnd_valid) got = 1'b1;
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int c;
        c = 0;
        while (c < budget && (tx_busy || fifo_level != 0)) begin
            @(negedge clk);
            c++;
        end
        chk(tag, tx_busy || (fifo_level != 0), 0);
    endtask

    initial begin
        int cyc;
        bit got;
        int vcnt;
        logic [9:0] seq;

        fork
            cyc_mon();
            uart_mon();
        join_none

        rst_n_buf = 1'b0;
        repeat (6) begin
            @(negedge clk);
            en = 1'($urandom);
            trnd_byte = 8'($urandom);
        end
        chk("rst_rnd_data", rnd_data, 8'h00);
        chk("rst_rnd_valid", rnd_valid, 0);
        chk("rst_fifo_level", fifo_level, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_uart_tx", uart_tx, 1);
        chk("rst_tx_busy", tx_busy, 0);
        en = 1'b0;
        rst_n_buf = 1'b1;
        repeat (3) @(negedge clk);

        en = 1'b1;
        trnd_byte = 8'h01;
        wait_valid(16 * SD * TPB, cyc, got);
`ifdef TRNG_VN_EN
        chk("vn_const_no_valid", got, 0);
`else
        chk("const01_valid_seen", got, 1);
        chk("const01_latency", cyc, 8 * SD);
        chk("const01_data", rnd_data, 8'hFF);
`endif
        @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);

        en = 1'b1;
`ifdef TRNG_VN_EN
        drive_raw(8'h01, 8'h00, 16);
        chk("vn_alt10_valid", rnd_valid, 1);
        chk("vn_alt10_data", rnd_data, 8'hFF);
        drive_raw(8'h00, 8'h01, 16);
        chk("vn_alt01_valid", rnd_valid, 1);
        chk("vn_alt01_data", rnd_data, 8'h00);
`else
        drive_raw(8'h03, 8'h03, 8);
        chk("const03_valid", rnd_valid, 1);
        chk("const03_data", rnd_data, 8'h00);
`endif
        en = 1'b0;
        wait_idle("idle_before_a5", 4 * (10 * BD + 1) + 50);

        en = 1'b1;
        drive_bits(8'hA5, 8);
        en = 1'b0;
        chk("a5_valid", rnd_valid, 1);
        chk("a5_data", rnd_data, 8'hA5);
        chk("a5_idle_cycle_line", uart_tx, 1);
        seq = 10'b1101001010;
        for (int k = 0; k <= 10 * BD; k++) begin
            @(posedge clk);
            #1;
            if (k < 10 * BD) begin
                if (k % BD == 0 || k % BD == BD - 1) chk("a5_line_bit", uart_tx, seq[k / BD]);
                if (k == 10 * BD - 1) chk("a5_busy_last", tx_busy, 1);
            end else begin
                chk("a5_busy_end", tx_busy, 0);
                chk("a5_line_end", uart_tx, 1);
            end
        end
        @(negedge clk);

        en = 1'b1;
        drive_bits(8'h6C, 5);
        en = 1'b0;
        vcnt = 0;
        repeat (1000) begin
            @(negedge clk);
            if (rnd_valid) vcnt++;
        end
        chk("en_gap_no_valid", vcnt, 0);
        en = 1'b1;
        drive_bits(8'h6C >> 5, 3);
        en = 1'b0;
        chk("en_resume_valid", rnd_valid, 1);
        chk("en_resume_data", rnd_data, 8'h6C);
        wait_idle("idle_before_ovf", 4 * (10 * BD + 1) + 50);

        en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            drive_bits(8'(8'h10 + i), 8);
            if (i == 1) chk("ovf_clear_early", overflow, 0);
        end
        en = 1'b0;
        chk("ovf_level_full", fifo_level, 16);
        chk("ovf_sticky", overflow, 1);
        wait_idle("drain_after_ovf", 20 * (10 * BD + 1) + 100);
        chk("ovf_tx_all_sent", q_tx.size(), 0);
        chk("ovf_still_sticky", overflow, 1);

        en = 1'b1;
        drive_bits(8'h3C, 8);
        drive_bits(8'hC3, 8);
        en = 1'b0;
        repeat (3 * BD) @(negedge clk);
        #2 rst_n_buf = 1'b0;
        #1;
        chk("midrst_uart_tx", uart_tx, 1);
        chk("midrst_tx_busy", tx_busy, 0);
        chk("midrst_fifo_level", fifo_level, 0);
        chk("midrst_overflow", overflow, 0);
        repeat (30) @(negedge clk);
        rst_n_buf = 1'b1;
        repeat (10 * BD + 10) @(negedge clk);
        chk("postrst_line_idle", uart_tx, 1);

        en = 1'b1;
        for (int i = 0; i < 3; i++) drive_bits(8'($urandom), 8);
        en = 1'b0;
        wait_idle("drain_random", 4 * (10 * BD + 1) + 100);
        chk("random_tx_all_sent", q_tx.size(), 0);
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
